stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_pkg.sv | 23 ++
 rtl/stack_ptr.sv | 33 +++
 rtl/stack_ctrl.sv | 141 ++++++++++++++
 tb/tb_stack_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and defaults for the stack controller: FSM states, command
// encoding and default geometry.
package stack_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam int SP_W      = $clog2(DEPTH_DEF) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_CAP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_PUSH,
    OP_POP,
    OP_TOS
  } op_t;

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer: entry count with one extra MSB so that full and empty are
// distinct; wraps modulo 2*DEPTH.
module stack_ptr #(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 clear,
  output logic [$clog2(DEPTH):0] sp,
  output logic                 full,
  output logic                 empty
);

  localparam int SPW = $clog2(DEPTH) + 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (inc) begin
      sp <= sp + SPW'(1);
    end else if (dec) begin
      sp <= sp - SPW'(1);
    end
  end

  assign empty = (sp == '0);
  assign full  = (sp == SPW'(DEPTH));

endmodule

// File: rtl/stack_ctrl.sv
// Stack controller driving an external single-port RAM (push / pop / tos).
// Define STACK_BOUNDS_CHECK_EN to reject push-when-full and pop/tos-when-empty
// with a sticky err flag; otherwise the pointer simply wraps.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_push,
  input  logic                   req_pop,
  input  logic                   req_tos,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   busy,
  output logic                   done,
  output logic                   empty,
  output logic                   full,
`ifdef STACK_BOUNDS_CHECK_EN
  output logic                   err,
`endif
  output logic [$clog2(DEPTH):0] sp,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic [WIDTH-1:0]       ram_wdata,
  output logic                   ram_we,
  output logic                   ram_re,
  input  logic [WIDTH-1:0]       ram_rdata
);

  localparam int AW = $clog2(DEPTH);

  state_t           state, state_nxt;
  op_t              req_op, op_q;
  logic             any_req, accept, bad_req;
  logic             sp_inc, sp_dec;
  logic [WIDTH-1:0] din_q;
  logic [AW-1:0]    sp_lo;

  assign any_req = req_push | req_pop | req_tos;
  assign accept  = (state == ST_IDLE) && any_req;
  assign req_op  = req_push ? OP_PUSH : (req_pop ? OP_POP : OP_TOS);
  assign sp_lo   = sp[AW-1:0];

`ifdef STACK_BOUNDS_CHECK_EN
  assign bad_req = (req_op == OP_PUSH) ? full : empty;
`else
  assign bad_req = 1'b0;
`endif

  stack_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .clear (1'b0),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          if (bad_req)                 state_nxt = ST_DONE;
          else if (req_op == OP_PUSH)  state_nxt = ST_WR;
          else                         state_nxt = ST_RD;
        end
      end
      ST_WR:   state_nxt = ST_DONE;
      ST_RD:   state_nxt = ST_CAP;
      ST_CAP:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and pointer updates are pure decodes of the current state.
  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = '0;
    sp_inc   = 1'b0;
    sp_dec   = 1'b0;
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    case (state)
      ST_WR: begin
        ram_we   = 1'b1;
        ram_addr = sp_lo;
        sp_inc   = 1'b1;
      end
      ST_RD: begin
        ram_re   = 1'b1;
        ram_addr = sp_lo - AW'(1);
        sp_dec   = (op_q == OP_POP);
      end
      default: ;
    endcase
  end

  assign ram_wdata = din_q;

  // Command capture on the accepting edge
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= req_op;
      din_q <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (state == ST_CAP) begin
      dout <= ram_rdata;
    end
  end

`ifdef STACK_BOUNDS_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && bad_req) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural RAM; covers both builds
// of STACK_BOUNDS_CHECK_EN.
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_push = 1'b0, req_pop = 1'b0, req_tos = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout, ram_wdata, ram_rdata;
  logic       busy, done, empty, full, ram_we, ram_re;
  logic [3:0] sp;
  logic [2:0] ram_addr;
`ifdef STACK_BOUNDS_CHECK_EN
  logic       err;
`endif

  always #5 clk = ~clk;

  stack_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_push  (req_push),
    .req_pop   (req_pop),
    .req_tos   (req_tos),
    .din       (din),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .empty     (empty),
    .full      (full),
`ifdef STACK_BOUNDS_CHECK_EN
    .err       (err),
`endif
    .sp        (sp),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata)
  );

  logic [7:0] mem [0:7];
  logic [2:0] last_we_addr = '0;
  int we_cnt = 0, re_cnt = 0, done_cnt = 0, both_cnt = 0;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      last_we_addr  <= ram_addr;
      we_cnt        <= we_cnt + 1;
    end
    if (ram_re) begin
      ram_rdata <= mem[ram_addr];
      re_cnt    <= re_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (ram_we && ram_re) both_cnt <= both_cnt + 1;
  end

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Raise the requests, drop them after 'hold' edges, and return the number
  // of edges until done is seen; finishes back in IDLE.
  task automatic run_cmd(input logic p, input logic q, input logic t,
                         input logic [7:0] d, input int hold, output int lat);
    req_push = p; req_pop = q; req_tos = t; din = d;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= hold) begin
        req_push = 1'b0; req_pop = 1'b0; req_tos = 1'b0;
      end
      if (done) break;
    end
    if (!done) begin
      check_eq("done_timeout", 32'(done), 32'd1);
      lat = 99;
    end
    @(posedge clk); #1;
  endtask

  int lat, w0, r0, d0;
  logic [7:0] pd [3];

  initial begin
    pd[0] = 8'h11; pd[1] = 8'h22; pd[2] = 8'h33;

    #1;
    check_eq("rst_sp_noclk", 32'(sp), 0);
    check_eq("rst_busy_done", {busy, done}, 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_sp", 32'(sp), 0);
    check_eq("rst_dout", 32'(dout), 0);
    check_eq("rst_strobes", {ram_we, ram_re, done, busy}, 0);
    check_eq("rst_empty", 32'(empty), 1);
`ifdef STACK_BOUNDS_CHECK_EN
    check_eq("rst_err", 32'(err), 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      run_cmd(1'b1, 1'b0, 1'b0, pd[i], 1, lat);
      check_eq("push_lat", 32'(lat), 2);
    end
    check_eq("push3_sp", 32'(sp), 3);
    check_eq("ram0", 32'(mem[0]), 32'h11);
    check_eq("ram1", 32'(mem[1]), 32'h22);
    check_eq("ram2", 32'(mem[2]), 32'h33);

    run_cmd(1'b0, 1'b0, 1'b1, 8'h00, 1, lat);
    check_eq("tos_lat", 32'(lat), 3);
    check_eq("tos_dout", 32'(dout), 32'h33);
    check_eq("tos_sp", 32'(sp), 3);

    run_cmd(1'b0, 1'b1, 1'b0, 8'h00, 1, lat);
    check_eq("pop1_lat", 32'(lat), 3);
    check_eq("pop1_dout", 32'(dout), 32'h33);
    check_eq("pop1_sp", 32'(sp), 2);
    run_cmd(1'b0, 1'b1, 1'b0, 8'h00, 1, lat);
    check_eq("pop2_lat", 32'(lat), 3);
    check_eq("pop2_dout", 32'(dout), 32'h22);
    check_eq("pop2_sp", 32'(sp), 1);

    // All three requests together, held through the busy period
    w0 = we_cnt; r0 = re_cnt; d0 = done_cnt;
    run_cmd(1'b1, 1'b1, 1'b1, 8'h44, 2, lat);
    repeat (2) @(posedge clk);
    #1;
    check_eq("prio_lat", 32'(lat), 2);
    check_eq("prio_sp", 32'(sp), 2);
    check_eq("prio_we", 32'(we_cnt - w0), 1);
    check_eq("prio_re", 32'(re_cnt - r0), 0);
    check_eq("prio_done", 32'(done_cnt - d0), 1);
    check_eq("prio_ram1", 32'(mem[1]), 32'h44);

    for (int i = 0; i < 6; i++) run_cmd(1'b1, 1'b0, 1'b0, 8'(8'h60 + i), 1, lat);
    check_eq("fill_sp", 32'(sp), 8);
    check_eq("fill_flags", {full, empty}, 2'b10);
`ifdef STACK_BOUNDS_CHECK_EN
    check_eq("fill_err", 32'(err), 0);
`endif

    w0 = we_cnt;
    run_cmd(1'b1, 1'b0, 1'b0, 8'h99, 1, lat);
`ifdef STACK_BOUNDS_CHECK_EN
    check_eq("ovf_lat", 32'(lat), 1);
    check_eq("ovf_err", 32'(err), 1);
    check_eq("ovf_sp", 32'(sp), 8);
    check_eq("ovf_we", 32'(we_cnt - w0), 0);
    check_eq("ovf_dout", 32'(dout), 32'h22);
`else
    check_eq("wrap_lat", 32'(lat), 2);
    check_eq("wrap_we", 32'(we_cnt - w0), 1);
    check_eq("wrap_addr", 32'(last_we_addr), 0);
    check_eq("wrap_sp", 32'(sp), 9);
    check_eq("wrap_full", 32'(full), 0);
`endif

    // Reset asserted while a pop is in RD
    d0 = done_cnt;
    req_pop = 1'b1;
    @(posedge clk); #1;
    req_pop = 1'b0;
    check_eq("abort_in_rd", {busy, ram_re}, 2'b11);
    rst = 1'b1;
    #1;
    check_eq("abort_sp", 32'(sp), 0);
    check_eq("abort_dout", 32'(dout), 0);
    check_eq("abort_outs", {busy, done, ram_re, ram_we}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_nodone", 32'(done_cnt - d0), 0);
`ifdef STACK_BOUNDS_CHECK_EN
    check_eq("abort_err_clr", 32'(err), 0);
`endif

    run_cmd(1'b1, 1'b0, 1'b0, 8'h55, 1, lat);
    check_eq("post_rst_addr", 32'(last_we_addr), 0);
    check_eq("post_rst_sp", 32'(sp), 1);
    run_cmd(1'b0, 1'b1, 1'b0, 8'h00, 1, lat);
    check_eq("post_rst_pop", 32'(dout), 32'h55);
    check_eq("post_rst_empty", {sp, empty}, 5'b0000_1);

    r0 = re_cnt;
    run_cmd(1'b0, 1'b1, 1'b0, 8'h00, 1, lat);
`ifdef STACK_BOUNDS_CHECK_EN
    check_eq("udf_lat", 32'(lat), 1);
    check_eq("udf_err", 32'(err), 1);
    check_eq("udf_re", 32'(re_cnt - r0), 0);
    check_eq("udf_sp", 32'(sp), 0);
    check_eq("udf_dout", 32'(dout), 32'h55);
`else
    check_eq("udf_lat", 32'(lat), 3);
    check_eq("udf_re", 32'(re_cnt - r0), 1);
    check_eq("udf_sp", 32'(sp), 15);
`endif

    check_eq("we_re_exclusive", 32'(both_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
